// File: rtl/calc_pkg.sv
// Symbol encoding and editor state shared by the input buffer and the
// picture generator's code-to-glyph mapping.
package calc_pkg;

    localparam logic [3:0] SYM_PLUS  = 4'hA;
    localparam logic [3:0] SYM_MINUS = 4'hB;
    localparam logic [3:0] SYM_MUL   = 4'hC;
    localparam logic [3:0] SYM_DIV   = 4'hD;
    localparam logic [3:0] SYM_EQ    = 4'hE;
    localparam logic [3:0] SYM_BLANK = 4'hF;

    typedef enum logic {
        EDIT = 1'b0,
        DONE = 1'b1
    } state_t;

    function automatic logic is_digit(input logic [3:0] sym);
        return (sym <= 4'd9);
    endfunction

endpackage

// File: rtl/display_latch.sv
// Frame-sync gated copy of the symbol vector; the display only ever sees
// a snapshot taken in vertical blank, so it never tears mid-frame.
module display_latch
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_sync,
    input  logic [4*DEPTH-1:0] data,
    output logic [4*DEPTH-1:0] numbers
);

    logic [4*DEPTH-1:0] numbers_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            numbers_reg <= {DEPTH{SYM_BLANK}};
        end else if (frame_sync) begin
            numbers_reg <= data;
        end
    end

    assign numbers = numbers_reg;

endmodule

// File: rtl/symbol_buffer.sv
// Key-entry line buffer: enforces digit/operator syntax, handles backspace
// and clear, and hands a packed symbol vector to the display latch.
module symbol_buffer
    import calc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    input  logic               bksp,
    input  logic               clr,
    input  logic               frame_sync,
    output logic [4*DEPTH-1:0] numbers,
    output logic [CW-1:0]      count,
    output logic               eq_pulse,
    output logic               err
);

    logic [3:0]   slot_reg  [DEPTH];
    logic [3:0]   slot_next [DEPTH];
    logic [CW-1:0] count_reg, count_next;
    state_t       state_reg, state_next;
    logic         eq_reg, eq_next;
    logic         err_reg, err_next;

    logic [CW-1:0] base_count;
    logic [3:0]    base_last;
    logic [4*DEPTH-1:0] work_vec;

    always_comb begin
        slot_next  = slot_reg;
        count_next = count_reg;
        state_next = state_reg;
        eq_next    = 1'b0;
        err_next   = 1'b0;
        base_count = count_reg;
        base_last  = SYM_BLANK;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(count_reg) - 1) base_last = slot_reg[i];
        end

        if (clr) begin
            for (int i = 0; i < DEPTH; i++) slot_next[i] = SYM_BLANK;
            count_next = '0;
            state_next = EDIT;
        end else if (bksp) begin
            if (count_reg != '0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(count_reg) - 1) slot_next[i] = SYM_BLANK;
                end
                count_next = count_reg - 1'b1;
                state_next = EDIT;
            end
        end else if (key_valid) begin
            if (key_code == SYM_BLANK) begin
                err_next = 1'b1;
            end else begin
                // A new key after '=' starts a fresh expression on an empty line.
                if (state_reg == DONE) begin
                    for (int i = 0; i < DEPTH; i++) slot_next[i] = SYM_BLANK;
                    base_count = '0;
                    base_last  = SYM_BLANK;
                    count_next = '0;
                    state_next = EDIT;
                end
                if (is_digit(key_code)) begin
                    if (int'(base_count) < DEPTH) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (i == int'(base_count)) slot_next[i] = key_code;
                        end
                        count_next = base_count + 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (base_count != '0 && int'(base_count) < DEPTH &&
                             is_digit(base_last)) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == int'(base_count)) slot_next[i] = key_code;
                    end
                    count_next = base_count + 1'b1;
                    if (key_code == SYM_EQ) begin
                        eq_next    = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    err_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_reg[i] <= SYM_BLANK;
            count_reg <= '0;
            state_reg <= EDIT;
            eq_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            slot_reg  <= slot_next;
            count_reg <= count_next;
            state_reg <= state_next;
            eq_reg    <= eq_next;
            err_reg   <= err_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
        assign work_vec[4*gi +: 4] = slot_reg[gi];
    end

    // Latch samples the pre-update buffer, so a same-cycle key shows next frame.
    display_latch #(.DEPTH(DEPTH)) u_display_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_sync (frame_sync),
        .data       (work_vec),
        .numbers    (numbers)
    );

    assign count    = count_reg;
    assign eq_pulse = eq_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_symbol_buffer.sv
// Directed scenarios for symbol_buffer with DEPTH=4; outputs are sampled
// 1 ns after the clock edge that applies each command.
module tb_symbol_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        bksp = 1'b0;
    logic        clr = 1'b0;
    logic        frame_sync = 1'b0;
    logic [15:0] numbers;
    logic [2:0]  count;
    logic        eq_pulse;
    logic        err;

    int pass_cnt = 0;
    int total_cnt = 0;

    symbol_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .bksp       (bksp),
        .clr        (clr),
        .frame_sync (frame_sync),
        .numbers    (numbers),
        .count      (count),
        .eq_pulse   (eq_pulse),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        bksp       = 1'b0;
        clr        = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic key(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        step();
        $display("key %h -> count=%0d err=%0b eq=%0b", code, count, err, eq_pulse);
    endtask

    task automatic frame();
        frame_sync = 1'b1;
        step();
        $display("frame_sync -> numbers=%h", numbers);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total_cnt++; if (numbers !== 16'hFFFF) $display("FAIL reset_numbers got %h want FFFF", numbers); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (eq_pulse !== 1'b0) $display("FAIL reset_eq got %b want 0", eq_pulse); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    endtask

    task automatic test_basic_entry();
        logic [3:0] seq [3];
        seq[0] = 4'h1; seq[1] = 4'hA; seq[2] = 4'h2;
        for (int i = 0; i < 3; i++) begin
            key(seq[i]);
            total_cnt++; if (err !== 1'b0) $display("FAIL basic_err key %0d got %b want 0", i, err); else pass_cnt++;
        end
        frame();
        total_cnt++; if (count !== 3'd3) $display("FAIL basic_count got %0d want 3", count); else pass_cnt++;
        total_cnt++; if (numbers !== 16'hF2A1) $display("FAIL basic_numbers got %h want F2A1", numbers); else pass_cnt++;
    endtask

    task automatic test_equals();
        do_clr();
        key(4'h1);
        key(4'hE);
        total_cnt++; if (eq_pulse !== 1'b1) $display("FAIL eq_pulse_high got %b want 1", eq_pulse); else pass_cnt++;
        total_cnt++; if (count !== 3'd2) $display("FAIL eq_count got %0d want 2", count); else pass_cnt++;
        step();
        total_cnt++; if (eq_pulse !== 1'b0) $display("FAIL eq_pulse_low got %b want 0", eq_pulse); else pass_cnt++;
        key(4'h7);
        total_cnt++; if (err !== 1'b0) $display("FAIL done_digit_err got %b want 0", err); else pass_cnt++;
        frame();
        total_cnt++; if (numbers !== 16'hFFF7) $display("FAIL done_digit_numbers got %h want FFF7", numbers); else pass_cnt++;
        total_cnt++; if (count !== 3'd1) $display("FAIL done_digit_count got %0d want 1", count); else pass_cnt++;
        // operator straight after '=' empties the line and is rejected
        key(4'h5);
        key(4'hE);
        key(4'hA);
        total_cnt++; if (err !== 1'b1 || count !== 3'd0) $display("FAIL done_op got err=%b count=%0d want err=1 count=0", err, count); else pass_cnt++;
    endtask

    task automatic test_syntax();
        do_clr();
        key(4'hA);
        total_cnt++; if (err !== 1'b1 || count !== 3'd0) $display("FAIL op_empty got err=%b count=%0d want err=1 count=0", err, count); else pass_cnt++;
        key(4'h3);
        total_cnt++; if (err !== 1'b0) $display("FAIL digit_after_err got %b want 0", err); else pass_cnt++;
        key(4'hB);
        total_cnt++; if (err !== 1'b0) $display("FAIL op_after_digit got %b want 0", err); else pass_cnt++;
        key(4'hC);
        total_cnt++; if (err !== 1'b1 || count !== 3'd2) $display("FAIL op_after_op got err=%b count=%0d want err=1 count=2", err, count); else pass_cnt++;
        key(4'hF);
        total_cnt++; if (err !== 1'b1 || count !== 3'd2) $display("FAIL illegal_key got err=%b count=%0d want err=1 count=2", err, count); else pass_cnt++;
        frame();
        total_cnt++; if (numbers !== 16'hFFB3) $display("FAIL syntax_numbers got %h want FFB3", numbers); else pass_cnt++;
    endtask

    task automatic test_full();
        do_clr();
        for (int i = 1; i <= 4; i++) key(4'(i));
        total_cnt++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else pass_cnt++;
        frame();
        total_cnt++; if (numbers !== 16'h4321) $display("FAIL full_numbers got %h want 4321", numbers); else pass_cnt++;
        key(4'h5);
        total_cnt++; if (err !== 1'b1 || count !== 3'd4) $display("FAIL overflow_digit got err=%b count=%0d want err=1 count=4", err, count); else pass_cnt++;
        key(4'hA);
        total_cnt++; if (err !== 1'b1 || count !== 3'd4) $display("FAIL overflow_op got err=%b count=%0d want err=1 count=4", err, count); else pass_cnt++;
        frame();
        total_cnt++; if (numbers !== 16'h4321) $display("FAIL overflow_numbers got %h want 4321", numbers); else pass_cnt++;
        bksp = 1'b1;
        step();
        total_cnt++; if (count !== 3'd3 || err !== 1'b0) $display("FAIL bksp got count=%0d err=%b want count=3 err=0", count, err); else pass_cnt++;
        frame();
        total_cnt++; if (numbers !== 16'hF321) $display("FAIL bksp_numbers got %h want F321", numbers); else pass_cnt++;
    endtask

    task automatic test_priority();
        do_clr();
        key(4'h1);
        key(4'h2);
        clr = 1'b1; bksp = 1'b1; key_valid = 1'b1; key_code = 4'h9;
        step();
        total_cnt++; if (count !== 3'd0 || err !== 1'b0) $display("FAIL clr_priority got count=%0d err=%b want count=0 err=0", count, err); else pass_cnt++;
        key(4'h5);
        bksp = 1'b1; key_valid = 1'b1; key_code = 4'h6;
        step();
        total_cnt++; if (count !== 3'd0 || err !== 1'b0) $display("FAIL bksp_priority got count=%0d err=%b want count=0 err=0", count, err); else pass_cnt++;
        bksp = 1'b1;
        step();
        total_cnt++; if (count !== 3'd0 || err !== 1'b0) $display("FAIL bksp_empty got count=%0d err=%b want count=0 err=0", count, err); else pass_cnt++;
        frame_sync = 1'b1;
        key(4'h9);
        total_cnt++; if (numbers !== 16'hFFFF || count !== 3'd1) $display("FAIL same_cycle_frame got numbers=%h count=%0d want FFFF 1", numbers, count); else pass_cnt++;
        frame();
        total_cnt++; if (numbers !== 16'hFFF9) $display("FAIL next_frame got %h want FFF9", numbers); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_clr();
        key(4'h1);
        key(4'h2);
        key(4'hE);
        frame();
        total_cnt++; if (numbers !== 16'hFE21 || count !== 3'd3) $display("FAIL pre_reset got numbers=%h count=%0d want FE21 3", numbers, count); else pass_cnt++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total_cnt++; if (numbers !== 16'hFFFF || count !== 3'd0 || eq_pulse !== 1'b0 || err !== 1'b0)
            $display("FAIL mid_reset got numbers=%h count=%0d eq=%b err=%b want FFFF 0 0 0", numbers, count, eq_pulse, err);
        else pass_cnt++;
        key(4'h8);
        frame();
        total_cnt++; if (numbers !== 16'hFFF8 || count !== 3'd1) $display("FAIL post_reset got numbers=%h count=%0d want FFF8 1", numbers, count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_equals();
        test_syntax();
        test_full();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
